// File: rtl/cmd_issue_queue.sv
// Command FIFO and issue sequencer feeding the atomic ALU controller.
// Commands issue one at a time; each syscall is followed by a per-opcode hold window.
module cmd_issue_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned OP_HOLD  = 1,
    parameter int unsigned CAS_HOLD = 2,
    parameter int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [11:0]      in_cmd,
    output logic             in_ready,
    input  logic             ctrl_ready,
    input  logic             flush,
    output logic [11:0]      command,
    output logic             syscall,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic [15:0]      issued_count
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned MAX_HOLD = (CAS_HOLD > OP_HOLD) ? CAS_HOLD : OP_HOLD;
    localparam int unsigned HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [2:0]  OPC_CAS  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [11:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [11:0]       command_q, command_d;
    logic              syscall_q, syscall_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       issued_q, issued_d;
    logic              push;
    logic              pop;

    // Full is judged from the registered count only, so a pop never frees a slot in the same cycle.
    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready && !flush;
    assign pop      = (state_q == IDLE) && (count_q != '0) && ctrl_ready && !flush;

    assign command      = command_q;
    assign syscall      = syscall_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign issued_count = issued_q;

    // FIFO pointers, occupancy and sticky overflow
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
            if (in_valid && !in_ready) overflow_d = 1'b1;
        end
    end

    // Issue sequencer
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        command_d = command_q;
        syscall_d = 1'b0;
        issued_d  = issued_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    command_d = mem_q[rd_ptr_q];
                    syscall_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                issued_d = issued_q + 16'd1;
                hold_d   = (command_q[11:9] == OPC_CAS) ? HOLD_W'(CAS_HOLD) : HOLD_W'(OP_HOLD);
                state_d  = HOLD;
            end
            HOLD: begin
                hold_d = hold_q - HOLD_W'(1);
                if (hold_q == HOLD_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d   = IDLE;
            syscall_d = 1'b0;
        end
    end

    // Storage array has no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_cmd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            command_q  <= 12'h000;
            syscall_q  <= 1'b0;
            overflow_q <= 1'b0;
            issued_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            command_q  <= command_d;
            syscall_q  <= syscall_d;
            overflow_q <= overflow_d;
            issued_q   <= issued_d;
        end
    end

endmodule

// File: doc/cmd_issue_queue.md
Name: cmd_issue_queue

Overview:
Command buffer and issue sequencer directly upstream of the atomic ALU controller. Accepts 12-bit commands (instruction[11:9], addr1[8:6], addr2[5:3], addr3[2:0]) from the host side through a valid/ready handshake and stores them in a FIFO. Issues them one at a time on `command`/`syscall`. After each issue it holds `command` stable for a fixed number of cycles, and longer for CAS (opcode 3'b111), so the controller finishes its read-modify-write before the next command arrives.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2
OP_HOLD, 1, hold cycles after syscall for non-CAS opcodes; minimum 1
CAS_HOLD, 2, hold cycles after syscall for CAS (opcode 3'b111); minimum 1
CNT_W, $clog2(DEPTH)+1, width of the occupancy count

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  host presents a command
in_cmd  input  12  host command word
in_ready  output  1  queue can accept a command this cycle
ctrl_ready  input  1  controller able to take a new command
flush  input  1  synchronous clear of queue and sequencer
command  output  12  command word to the controller
syscall  output  1  one-cycle RUN strobe to the controller
count  output  CNT_W  current FIFO occupancy
overflow  output  1  sticky flag: write attempted while full
issued_count  output  16  number of commands issued; wraps modulo 2^16

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO pointers and count = 0; state = IDLE.
  - command = 12'h000, syscall = 0, overflow = 0, issued_count = 0.
  - in_ready = 1 once rst_n is high.
- Reset asserted mid-operation aborts everything immediately; no syscall is generated afterwards for queued or in-flight commands.
- Write side:
  - in_ready = (count != DEPTH), decoded from registered count only; there is no same-cycle pop bypass.
  - Push occurs when in_valid && in_ready.
  - in_valid && !in_ready sets overflow; the command is dropped and FIFO contents are unchanged.
- Read pointer and write pointer wrap modulo DEPTH.
- Push and pop in the same cycle leave count unchanged.
- State machine states: IDLE, ISSUE, HOLD.
  - IDLE: if count != 0 && ctrl_ready && !flush, pop the head entry into the command register and go to ISSUE. Otherwise stay; command keeps its last value.
  - ISSUE: syscall = 1 for exactly this one cycle. Load the hold counter with CAS_HOLD if command[11:9] == 3'b111, else OP_HOLD. Increment issued_count. Go to HOLD.
  - HOLD: syscall = 0, command stable. Decrement the hold counter; when it reaches 1, return to IDLE on the next edge (HOLD lasts exactly the loaded number of cycles).
- ctrl_ready is sampled only in IDLE; deasserting it during ISSUE or HOLD has no effect on the command in flight.
- Timing:
  - Push-to-syscall latency on an empty queue with ctrl_ready = 1: the pushed entry is visible in IDLE on the cycle after the push edge and is popped that cycle. syscall is high on the next cycle, i.e. 2 cycles after the push edge.
  - Back-to-back syscall spacing: 2 + OP_HOLD cycles for non-CAS (3 at default); 2 + CAS_HOLD cycles for CAS (4 at default).
- flush (synchronous, highest priority over push/pop):
  - Empties the FIFO, clears overflow, state -> IDLE, syscall = 0 next cycle.
  - Applies in any state. If asserted in the ISSUE cycle, that syscall still appears, since it is already registered; the hold is abandoned.
  - A push in the same cycle as flush is discarded.
  - command and issued_count are not cleared by flush.
- All outputs are registered except in_ready, which is decoded from registered count.

Test Plan:
- Reset, then push cmd 12'h0C8 (add r3,r1) on an empty queue with ctrl_ready = 1 -> syscall high exactly 2 cycles after the push edge; command = 12'h0C8; issued_count = 1; count returns to 0.
- Push 3 non-CAS commands back-to-back, ctrl_ready = 1 -> three syscall pulses 3 cycles apart, in FIFO order; command constant between pulses.
- Push CAS 12'hE53 then 12'h0C8 -> CAS syscall, then second syscall 4 cycles later; command = 12'hE53 for all 4 cycles in between.
- Hold ctrl_ready = 0 and push 9 commands (DEPTH = 8) -> in_ready = 0 after the 8th; 9th dropped; overflow = 1; count = 8. Then release ctrl_ready -> exactly 8 syscalls; last command = 8th pushed.
- Queue 4 commands; flush during HOLD of the first -> count = 0, overflow = 0, no further syscall; issued_count = 1.
- Drop rst_n during HOLD with 3 queued -> all outputs at reset values immediately; no syscall after release.
